// File: rtl/miriscv_mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package miriscv_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_INSTR,
    OWN_DATA
  } arb_owner_e;

  localparam logic [3:0] ARB_INSTR_BE = 4'hF;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/miriscv_mem_arbiter_prio.sv
// Data-first winner selection with a starvation counter that forces an
// instruction fetch through after STARVE_LIMIT consecutive data wins.
module miriscv_arb_prio
  import miriscv_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       instr_req,
  input  logic       data_req,
  input  logic       arb_en,
  output logic       winner_valid,
  output arb_owner_e winner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       instr_forced;

  assign instr_forced = instr_req && (starve_cnt == LIMIT);
  assign winner_valid = instr_req | data_req;
  assign winner       = (data_req && !instr_forced) ? OWN_DATA : OWN_INSTR;

  // Only data wins that left a fetch waiting count toward starvation.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      starve_cnt <= '0;
    end else if (arb_en && winner_valid) begin
      if (winner == OWN_DATA && instr_req) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU,
// one outstanding transaction at a time.
module miriscv_mem_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        arstn_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic        err_o
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q;
  arb_req_t   req_q, win_req;
  logic       err_q;

  logic       arb_en, win_valid, capture;
  arb_owner_e winner;

  assign arb_en  = (state_q == ARB_IDLE) || (state_q == ARB_RESP && mem_rvalid_i);
  assign capture = arb_en && win_valid;

  miriscv_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .instr_req    (instr_req_i),
    .data_req     (data_req_i),
    .arb_en       (arb_en),
    .winner_valid (win_valid),
    .winner       (winner)
  );

  always_comb begin
    win_req = '{we: 1'b0, be: ARB_INSTR_BE, addr: instr_addr_i, wdata: 32'h0};
    if (winner == OWN_DATA)
      win_req = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_INSTR;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        owner_q <= winner;
        req_q   <= win_req;
      end
      // Responses or grants the FSM is not waiting for are protocol errors.
      if ((mem_rvalid_i && state_q != ARB_RESP) || (mem_gnt_i && state_q != ARB_ADDR))
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (win_valid) state_d = ARB_ADDR;
      ARB_ADDR: if (mem_gnt_i) state_d = ARB_RESP;
      ARB_RESP: if (mem_rvalid_i) state_d = win_valid ? ARB_ADDR : ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    if (state_q == ARB_ADDR && mem_gnt_i) begin
      instr_gnt_o = (owner_q == OWN_INSTR);
      data_gnt_o  = (owner_q == OWN_DATA);
    end
    if (state_q == ARB_RESP && mem_rvalid_i) begin
      instr_rvalid_o = (owner_q == OWN_INSTR);
      data_rvalid_o  = (owner_q == OWN_DATA);
    end
  end

  assign mem_req_o     = (state_q == ARB_ADDR);
  assign mem_we_o      = req_q.we;
  assign mem_be_o      = req_q.be;
  assign mem_addr_o    = req_q.addr;
  assign mem_wdata_o   = req_q.wdata;

  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign err_o         = err_q;

endmodule
